d_flip_flop: RTL and testbench
==============================

Name: d_flip_flop

Overview:
Positive-edge-triggered D flip-flop with a synchronous active-high reset and complementary outputs q and qbar. It is the basic storage element for single-bit state and registered signals, and is widened by a parameter for small register uses. Purely sequential storage. No enable, no asynchronous paths.

Parameters:
WIDTH, 1, bit width of d, q and qbar (must be >= 1).
RESET_VALUE, {WIDTH{1'b0}}, value loaded into q on reset.

Ports:
clk  input  1  clock; all state changes on the rising edge only.
rst  input  1  synchronous reset, active-high; sampled on the rising edge of clk.
d  input  WIDTH  data input; sampled on the rising edge of clk.
q  output  WIDTH  registered output.
qbar  output  WIDTH  bitwise complement of q.

Behaviour:
- One clock domain (clk). Reset is synchronous and active-high; there is no asynchronous reset.
- On each rising edge of clk:
  - rst=1: q <= RESET_VALUE (reset has priority over d).
  - rst=0: q <= d.
- Latency is 1 cycle. q reflects the value of d sampled at the rising edge, and is visible immediately after that edge.
- Between edges, q holds its value. Changes on d or rst away from a rising edge have no effect.
- Falling edges of clk have no effect.
- qbar == ~q at all times, bitwise.
  - qbar is derived combinationally from the stored q. It is not a separate register, so q and qbar can never disagree.
- After reset: q = RESET_VALUE and qbar = ~RESET_VALUE, starting from the edge on which rst was sampled high.
- Reset assertion and deassertion:
  - rst asserted for N edges: q stays RESET_VALUE for all N edges.
  - First edge with rst=0 loads d.
- rst and d changing together: the values present at the edge are used. rst=1 wins regardless of d.
- Power-up before the first rising edge: q and qbar are undefined (X in simulation). Verification must not check outputs before the first edge at which either rst=1 or d has been driven to a known value.
- d changing at the same simulation time as a non-edge (e.g., on the falling edge) must never alter q.
- Width: each bit is independent; bit i of q follows bit i of d.
- Requirement on the bench: it drives rst to 0 or 1 at all times; rst must not be left floating.

Test Plan:
- Reset: rst=1, d=1, one rising edge -> q=0, qbar=1. Hold rst=1 with d toggling over 3 edges -> q stays 0 every edge.
- Basic capture: clk period 10 with rising edges at t=5,15,25,35. rst=0, d starts 0 and toggles at t=10,20,30 -> after edge at t=5 q=0,qbar=1; t=15 q=1,qbar=0; t=25 q=0,qbar=1; t=35 q=1,qbar=0.
- Hold between edges: set q=1, then pulse d 1->0->1 entirely within a low or high clock phase that contains no rising edge -> q remains 1 and qbar remains 0 throughout.
- Reset priority and release: q=1, then rst=1 with d=1 at an edge -> q=0. Next edge with rst=0 and d=1 -> q=1.
- Complement invariant: random d and rst over 200 cycles -> qbar == ~q at every sample point after the first edge. Each q equals the prior-edge d, or RESET_VALUE if rst was 1 at that edge.
- Parameterised: WIDTH=8, RESET_VALUE=8'hA5. Reset edge -> q=8'hA5, qbar=8'h5A. Then d=8'h3C at an edge -> q=8'h3C, qbar=8'hC3.

Source files
------------

// File: rtl/d_flip_flop.sv
// ============================================================================
//  Module      : d_flip_flop
//  Description : Rising-edge D flip-flop, synchronous active-high reset,
//                parameterised width, complementary q / qbar outputs.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module d_flip_flop #(
    parameter int                 WIDTH       = 1,
    parameter logic [WIDTH-1:0]   RESET_VALUE = {WIDTH{1'b0}}
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qbar
);

    logic [WIDTH-1:0] r_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_q <= RESET_VALUE;
        end else begin
            r_q <= d;
        end
    end

    // qbar comes from the single stored value, so the pair can never disagree.
    assign q    = r_q;
    assign qbar = ~r_q;

endmodule

`default_nettype wire

// File: tb/tb_d_flip_flop.sv
// ============================================================================
//  Module      : tb_d_flip_flop
//  Description : Self-checking bench for d_flip_flop (1-bit and 8-bit/A5).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_d_flip_flop;

    localparam logic [7:0] c_RV8 = 8'hA5;

    logic       clk = 1'b0;
    logic       rst;
    logic [0:0] d;
    logic [0:0] q;
    logic [0:0] qbar;
    logic       rst8;
    logic [7:0] d8;
    logic [7:0] q8;
    logic [7:0] qbar8;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    d_flip_flop u_dut1 (
        .clk  (clk),
        .rst  (rst),
        .d    (d),
        .q    (q),
        .qbar (qbar)
    );

    d_flip_flop #(
        .WIDTH       (8),
        .RESET_VALUE (c_RV8)
    ) u_dut8 (
        .clk  (clk),
        .rst  (rst8),
        .d    (d8),
        .q    (q8),
        .qbar (qbar8)
    );

    // Reference rule: a clocked edge yields the reset value if rst was high, else d.
    function automatic logic [7:0] ref_next(input logic r, input logic [7:0] din,
                                            input logic [7:0] rv);
        return r ? rv : din;
    endfunction

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1;
        d   = 1'b1;
        @(posedge clk);
        #1;
        total++;
        if (q !== 1'b0 || qbar !== 1'b1) begin
            bad++;
            $display("FAIL reset_first q=%b qbar=%b expected q=0 qbar=1", q, qbar);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            d = ~d;
            @(posedge clk);
            #1;
            total++;
            if (q !== 1'b0 || qbar !== 1'b1) begin
                bad++;
                $display("FAIL reset_hold[%0d] q=%b qbar=%b expected q=0 qbar=1", i, q, qbar);
            end
        end
    endtask

    task automatic test_basic_capture();
        logic exp;
        @(negedge clk);
        rst = 1'b0;
        d   = 1'b0;
        exp = 1'b0;
        @(posedge clk);
        #1;
        total++;
        if (q !== exp || qbar !== ~exp) begin
            bad++;
            $display("FAIL capture[0] q=%b qbar=%b expected q=%b qbar=%b", q, qbar, exp, ~exp);
        end
        for (int i = 1; i <= 3; i++) begin
            @(negedge clk);
            d   = ~d;
            exp = ~exp;
            @(posedge clk);
            #1;
            total++;
            if (q !== exp || qbar !== ~exp) begin
                bad++;
                $display("FAIL capture[%0d] q=%b qbar=%b expected q=%b qbar=%b", i, q, qbar, exp, ~exp);
            end
        end
    endtask

    task automatic test_hold();
        @(negedge clk);
        rst = 1'b0;
        d   = 1'b1;
        @(posedge clk);
        #1;
        total++;
        if (q !== 1'b1) begin
            bad++;
            $display("FAIL hold_setup q=%b expected 1", q);
        end
        // Glitch d inside the high phase.
        #1 d = 1'b0;
        #1;
        total++;
        if (q !== 1'b1 || qbar !== 1'b0) begin
            bad++;
            $display("FAIL hold_high q=%b qbar=%b expected q=1 qbar=0", q, qbar);
        end
        #1 d = 1'b1;
        // Change d exactly on the falling edge, then glitch through the low phase.
        @(negedge clk);
        d = 1'b0;
        #1;
        total++;
        if (q !== 1'b1 || qbar !== 1'b0) begin
            bad++;
            $display("FAIL hold_negedge q=%b qbar=%b expected q=1 qbar=0", q, qbar);
        end
        #1 d = 1'b1;
        #1;
        total++;
        if (q !== 1'b1 || qbar !== 1'b0) begin
            bad++;
            $display("FAIL hold_low q=%b qbar=%b expected q=1 qbar=0", q, qbar);
        end
    endtask

    task automatic test_reset_priority();
        @(negedge clk);
        rst = 1'b1;
        d   = 1'b1;
        @(posedge clk);
        #1;
        total++;
        if (q !== 1'b0 || qbar !== 1'b1) begin
            bad++;
            $display("FAIL rst_priority q=%b qbar=%b expected q=0 qbar=1", q, qbar);
        end
        @(negedge clk);
        rst = 1'b0;
        d   = 1'b1;
        @(posedge clk);
        #1;
        total++;
        if (q !== 1'b1 || qbar !== 1'b0) begin
            bad++;
            $display("FAIL rst_release q=%b qbar=%b expected q=1 qbar=0", q, qbar);
        end
    endtask

    task automatic test_param();
        @(negedge clk);
        rst8 = 1'b1;
        d8   = 8'($urandom);
        @(posedge clk);
        #1;
        total++;
        if (q8 !== 8'hA5 || qbar8 !== 8'h5A) begin
            bad++;
            $display("FAIL param_reset q=%h qbar=%h expected q=a5 qbar=5a", q8, qbar8);
        end
        @(negedge clk);
        rst8 = 1'b0;
        d8   = 8'h3C;
        @(posedge clk);
        #1;
        total++;
        if (q8 !== 8'h3C || qbar8 !== 8'hC3) begin
            bad++;
            $display("FAIL param_load q=%h qbar=%h expected q=3c qbar=c3", q8, qbar8);
        end
    endtask

    task automatic test_random();
        logic       r1;
        logic       dv1;
        logic       r8;
        logic [7:0] dv8;
        logic [7:0] exp1;
        logic [7:0] exp8;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            r1   = ($urandom_range(0, 3) == 0);
            dv1  = 1'($urandom);
            r8   = ($urandom_range(0, 3) == 0);
            dv8  = 8'($urandom);
            rst  = r1;
            d    = dv1;
            rst8 = r8;
            d8   = dv8;
            @(posedge clk);
            exp1 = ref_next(r1, {7'b0, dv1}, 8'h00);
            exp8 = ref_next(r8, dv8, c_RV8);
            #1;
            // Scramble inputs mid-phase; only the values at the edge may matter.
            d  = 1'($urandom);
            d8 = 8'($urandom);
            #1;
            total++;
            if (q !== exp1[0] || qbar !== ~q) begin
                bad++;
                $display("FAIL rand1[%0d] q=%b qbar=%b expected q=%b qbar=%b", i, q, qbar, exp1[0], ~exp1[0]);
            end
            total++;
            if (q8 !== exp8 || qbar8 !== ~q8) begin
                bad++;
                $display("FAIL rand8[%0d] q=%h qbar=%h expected q=%h qbar=%h", i, q8, qbar8, exp8, ~exp8);
            end
        end
    endtask

    initial begin
        rst  = 1'b1;
        d    = 1'b0;
        rst8 = 1'b1;
        d8   = 8'h00;
        test_reset();
        test_basic_capture();
        test_hold();
        test_reset_priority();
        test_param();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

endmodule

`default_nettype wire
